// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle unsigned arithmetic unit.
// Single-cycle ADD/SUB/INC/DEC, shift-and-add MUL and restoring DIV
// (WORD_SIZE iterations each), with a start/ready/done handshake.
// Build option: define ARITH_DIV_EN to compile in the divider; without it
// opcode DIV is treated as an illegal opcode.
module seq_arith_unit #(
   parameter int WORD_SIZE    = 19,
   parameter int OPCODE_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    ready,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic [WORD_SIZE-1:0]    operand_1,
   input  logic [WORD_SIZE-1:0]    operand_2,
   output logic [WORD_SIZE-1:0]    result,
   output logic [WORD_SIZE-1:0]    result_hi,
   output logic                    done,
   output logic                    carry,
   output logic                    zero,
   output logic                    ovf,
   output logic                    err
);

   localparam int CNT_W = $clog2(WORD_SIZE);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WORD_SIZE - 1);

   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(2);
`ifdef ARITH_DIV_EN
   localparam logic [OPCODE_WIDTH-1:0] OP_DIV = OPCODE_WIDTH'(3);
`endif
   localparam logic [OPCODE_WIDTH-1:0] OP_INC = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_DEC = OPCODE_WIDTH'(5);

`ifdef ARITH_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FINISH} state_t;
`else
   typedef enum logic [1:0] {IDLE, MUL_RUN, FINISH} state_t;
`endif

   state_t                 r_state;
   state_t                 w_state_nx;
   logic                   w_accept;

   // Iterative datapath working registers. r_opr holds the multiplicand
   // (MUL) or divisor (DIV); {r_acc_hi, r_acc_lo} is the shifting
   // product / remainder-quotient pair.
   logic [CNT_W-1:0]       r_cnt;
   logic [WORD_SIZE-1:0]   r_opr;
   logic [WORD_SIZE-1:0]   r_acc_hi;
   logic [WORD_SIZE-1:0]   r_acc_lo;

   // Registered outputs.
   logic [WORD_SIZE-1:0]   r_result;
   logic [WORD_SIZE-1:0]   r_result_hi;
   logic                   r_done;
   logic                   r_carry;
   logic                   r_zero;
   logic                   r_ovf;
   logic                   r_err;

   // Single-cycle results; bit WORD_SIZE of w_alu_wide is carry/borrow.
   logic [WORD_SIZE:0]     w_alu_wide;
   logic [WORD_SIZE-1:0]   w_alu_hi;
   logic                   w_alu_err;

   // One shift-and-add multiply step.
   logic [WORD_SIZE:0]     w_mul_sum;
   logic [WORD_SIZE-1:0]   w_mul_hi_nx;
   logic [WORD_SIZE-1:0]   w_mul_lo_nx;

`ifdef ARITH_DIV_EN
   // One restoring-division step.
   logic [WORD_SIZE:0]     w_div_shift;
   logic [WORD_SIZE+1:0]   w_div_trial;
   logic                   w_div_fit;
   logic [WORD_SIZE-1:0]   w_div_hi_nx;
   logic [WORD_SIZE-1:0]   w_div_lo_nx;
   logic                   w_div_unused;
`endif

   assign w_accept  = start && (r_state == IDLE);
   assign ready     = (r_state == IDLE);
   assign done      = r_done;
   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign ovf       = r_ovf;
   assign err       = r_err;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // Next-state: multi-cycle ops iterate, everything else completes at once.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (opcode == OP_MUL) begin
                  w_state_nx = MUL_RUN;
`ifdef ARITH_DIV_EN
               end else if ((opcode == OP_DIV) && (operand_2 != '0)) begin
                  w_state_nx = DIV_RUN;
`endif
               end else begin
                  w_state_nx = FINISH;
               end
            end
         end
         MUL_RUN: begin
            if (r_cnt == LAST_ITER) begin
               w_state_nx = FINISH;
            end
         end
`ifdef ARITH_DIV_EN
         DIV_RUN: begin
            if (r_cnt == LAST_ITER) begin
               w_state_nx = FINISH;
            end
         end
`endif
         FINISH:  w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // Single-cycle ops, evaluated on the live inputs during the accept cycle.
   always_comb begin
      w_alu_wide = '0;
      w_alu_hi   = '0;
      w_alu_err  = 1'b0;
      case (opcode)
         OP_ADD: w_alu_wide = {1'b0, operand_1} + {1'b0, operand_2};
         OP_SUB: w_alu_wide = {1'b0, operand_1} - {1'b0, operand_2};
         OP_INC: w_alu_wide = {1'b0, operand_1} + (WORD_SIZE+1)'(1);
         OP_DEC: w_alu_wide = {1'b0, operand_1} - (WORD_SIZE+1)'(1);
         OP_MUL: w_alu_wide = '0;
`ifdef ARITH_DIV_EN
         // Only reaches completion from here when the divisor is zero.
         OP_DIV: begin
            w_alu_wide = {1'b0, {WORD_SIZE{1'b1}}};
            w_alu_hi   = operand_1;
            w_alu_err  = 1'b1;
         end
`endif
         default: w_alu_err = 1'b1;
      endcase
   end

   // Multiply step: add multiplicand when the multiplier LSB is set, then
   // shift the whole product pair right by one.
   always_comb begin
      w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opr} : '0);
      w_mul_hi_nx = w_mul_sum[WORD_SIZE:1];
      w_mul_lo_nx = {w_mul_sum[0], r_acc_lo[WORD_SIZE-1:1]};
   end

`ifdef ARITH_DIV_EN
   // Divide step: shift in the next dividend bit, trial-subtract the
   // divisor and restore when the trial goes negative. The remainder is
   // always below the divisor, so the trial's bit WORD_SIZE is never needed.
   always_comb begin
      w_div_shift  = {r_acc_hi, r_acc_lo[WORD_SIZE-1]};
      w_div_trial  = {1'b0, w_div_shift} - {2'b00, r_opr};
      w_div_fit    = ~w_div_trial[WORD_SIZE+1];
      w_div_hi_nx  = w_div_fit ? w_div_trial[WORD_SIZE-1:0] : w_div_shift[WORD_SIZE-1:0];
      w_div_lo_nx  = {r_acc_lo[WORD_SIZE-2:0], w_div_fit};
      w_div_unused = w_div_trial[WORD_SIZE];
   end
`endif

   // Iterative datapath: capture operands on accept, then step once per cycle.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_cnt    <= '0;
         r_acc_hi <= '0;
`ifdef ARITH_DIV_EN
         if (opcode == OP_DIV) begin
            r_acc_lo <= operand_1;
            r_opr    <= operand_2;
         end else begin
            r_acc_lo <= operand_2;
            r_opr    <= operand_1;
         end
`else
         r_acc_lo <= operand_2;
         r_opr    <= operand_1;
`endif
      end else if (r_state == MUL_RUN) begin
         r_cnt    <= r_cnt + CNT_W'(1);
         r_acc_hi <= w_mul_hi_nx;
         r_acc_lo <= w_mul_lo_nx;
      end
`ifdef ARITH_DIV_EN
      else if (r_state == DIV_RUN) begin
         r_cnt    <= r_cnt + CNT_W'(1);
         r_acc_hi <= w_div_hi_nx;
         r_acc_lo <= w_div_lo_nx;
      end
`endif
   end

   // Outputs only change on the edge that raises done, so they hold between dones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_result_hi <= '0;
         r_done      <= 1'b0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept && (w_state_nx == FINISH)) begin
            r_result    <= w_alu_wide[WORD_SIZE-1:0];
            r_result_hi <= w_alu_hi;
            r_carry     <= w_alu_wide[WORD_SIZE];
            r_zero      <= (w_alu_wide[WORD_SIZE-1:0] == '0);
            r_ovf       <= 1'b0;
            r_err       <= w_alu_err;
            r_done      <= 1'b1;
         end else if ((r_state == MUL_RUN) && (r_cnt == LAST_ITER)) begin
            r_result    <= w_mul_lo_nx;
            r_result_hi <= w_mul_hi_nx;
            r_carry     <= 1'b0;
            r_zero      <= (w_mul_lo_nx == '0);
            r_ovf       <= (w_mul_hi_nx != '0);
            r_err       <= 1'b0;
            r_done      <= 1'b1;
         end
`ifdef ARITH_DIV_EN
         else if ((r_state == DIV_RUN) && (r_cnt == LAST_ITER)) begin
            r_result    <= w_div_lo_nx;
            r_result_hi <= w_div_hi_nx;
            r_carry     <= 1'b0;
            r_zero      <= (w_div_lo_nx == '0);
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Testbench for seq_arith_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_seq_arith_unit;

   localparam int W  = 19;
   localparam int OW = 5;
   localparam longint unsigned M = (64'd1 << W) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [OW-1:0] opcode = '0;
   logic [W-1:0]  operand_1 = '0;
   logic [W-1:0]  operand_2 = '0;
   logic          ready, done, carry, zero, ovf, err;
   logic [W-1:0]  result, result_hi;

   int n_cmp = 0;
   int n_bad = 0;

   seq_arith_unit #(.WORD_SIZE(W), .OPCODE_WIDTH(OW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
      .opcode(opcode), .operand_1(operand_1), .operand_2(operand_2),
      .result(result), .result_hi(result_hi), .done(done),
      .carry(carry), .zero(zero), .ovf(ovf), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operation's definition.
   function automatic void model(input int op, input longint unsigned a, input longint unsigned b,
                                 output longint unsigned r, output longint unsigned h,
                                 output logic c, output logic o, output logic e, output int lat);
      longint unsigned p;
      r = 0; h = 0; c = 0; o = 0; e = 0; lat = 1;
      case (op)
         0: begin p = a + b; r = p & M; c = (p > M); end
         1: begin r = (a - b) & M; c = (a < b); end
         2: begin p = a * b; r = p & M; h = p >> W; o = (h != 0); lat = W + 1; end
`ifdef ARITH_DIV_EN
         3: begin
            if (b == 0) begin r = M; h = a; e = 1; end
            else begin r = a / b; h = a % b; lat = W + 1; end
         end
`endif
         4: begin r = (a + 1) & M; c = (a == M); end
         5: begin r = (a - 1) & M; c = (a == 0); end
         default: e = 1;
      endcase
   endfunction

   task automatic run_op(input string tag, input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint unsigned er, eh;
      logic ec, eo, ee;
      int elat, lat;
      model(int'(op), a, b, er, eh, ec, eo, ee, elat);
      @(negedge clk);
      for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
      opcode = op; operand_1 = a; operand_2 = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      opcode = OW'($urandom); operand_1 = W'($urandom); operand_2 = W'($urandom);
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
      chk_val({tag, "_lat"},   lat, elat);
      chk_val({tag, "_res"},   result, er);
      chk_val({tag, "_hi"},    result_hi, eh);
      chk_val({tag, "_carry"}, carry, ec);
      chk_val({tag, "_zero"},  zero, (er == 0));
      chk_val({tag, "_ovf"},   ovf, eo);
      chk_val({tag, "_err"},   err, ee);
      @(negedge clk);
      chk_val({tag, "_pulse"}, done, 0);
      chk_val({tag, "_ready"}, ready, 1);
      chk_val({tag, "_hold"},  result, er);
   endtask

   initial begin
      int n_low, n_done;
      logic [OW-1:0] rop;
      logic [W-1:0]  ra, rb;

      // Reset state
      #12;
      chk_val("rst_ready", ready, 1);
      chk_val("rst_done", done, 0);
      chk_val("rst_res", result, 0);
      chk_val("rst_hi", result_hi, 0);
      chk_val("rst_flags", {carry, zero, ovf, err}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed corner cases
      run_op("add_wrap", 5'h00, 19'h7FFFF, 19'h00001);
      chk_val("add_wrap_k", {carry, zero, ovf, err, result}, {4'b1100, 19'h00000});
      run_op("mul_1000", 5'h02, 19'd1000, 19'd1000);
      chk_val("mul_1000_k", {ovf, result_hi, result}, {1'b1, 19'h00001, 19'h74240});
      run_op("div_100_7", 5'h03, 19'd100, 19'd7);
      run_op("div_100_0", 5'h03, 19'd100, 19'd0);
`ifdef ARITH_DIV_EN
      chk_val("div_100_0_k", {err, result_hi, result}, {1'b1, 19'd100, 19'h7FFFF});
`else
      chk_val("div_off_k", {err, zero, result}, {1'b1, 1'b1, 19'h0});
`endif
      run_op("sub_5_9", 5'h01, 19'd5, 19'd9);
      chk_val("sub_5_9_k", {carry, result}, {1'b1, 19'h7FFFC});
      run_op("dec_0", 5'h05, 19'd0, W'($urandom));
      chk_val("dec_0_k", {carry, result}, {1'b1, 19'h7FFFF});
      run_op("inc_max", 5'h04, 19'h7FFFF, W'($urandom));
      run_op("illegal_1f", 5'h1F, 19'd77, 19'd88);
      chk_val("illegal_1f_k", {err, zero, result}, {1'b1, 1'b1, 19'h0});
      run_op("mul_max", 5'h02, 19'h7FFFF, 19'h7FFFF);
      run_op("div_max_1", 5'h03, 19'h7FFFF, 19'd1);

      // Start held high every cycle during a MUL: one accept, one done
      @(negedge clk);
      opcode = 5'h02; operand_1 = 19'd1234; operand_2 = 19'd567; start = 1'b1;
      @(posedge clk);
      n_low = 0; n_done = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ready) break;
         n_low++;
         if (done) n_done++;
         opcode = 5'h00; operand_1 = W'($urandom); operand_2 = W'($urandom); start = 1'b1;
      end
      start = 1'b0;
      chk_val("busy_ready_low", n_low, W + 1);
      chk_val("busy_done_cnt", n_done, 1);
      chk_val("busy_res", result, (64'd1234 * 64'd567) & M);
      repeat (3) begin
         @(negedge clk);
         chk_val("busy_no_second", done, 0);
      end

      // Reset in the middle of a MUL
      run_op("pre_rst_sub", 5'h01, 19'd3, 19'd10);
      @(negedge clk);
      opcode = 5'h02; operand_1 = 19'd1000; operand_2 = 19'd1000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_val("midrst_ready", ready, 1);
      chk_val("midrst_done", done, 0);
      chk_val("midrst_res", result, 0);
      chk_val("midrst_hi", result_hi, 0);
      chk_val("midrst_flags", {carry, zero, ovf, err}, 4'b0000);
      @(negedge clk);
      opcode = 5'h00; operand_1 = 19'd123; operand_2 = 19'd456; start = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk_val("postrst_done", done, 1);
      chk_val("postrst_res", result, 579);
      chk_val("postrst_flags", {carry, zero, ovf, err}, 4'b0000);
      n_done = 0;
      repeat (W + 5) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk_val("postrst_no_ghost", n_done, 0);

      // Randomized operations
      for (int k = 0; k < 60; k++) begin
         case ($urandom_range(0, 7))
            0: rop = 5'h00;
            1: rop = 5'h01;
            2: rop = 5'h02;
            3: rop = 5'h03;
            4: rop = 5'h04;
            5: rop = 5'h05;
            6: rop = 5'h02;
            default: rop = OW'($urandom_range(6, 31));
         endcase
         case ($urandom_range(0, 3))
            0: ra = '0;
            1: ra = W'(M);
            default: ra = W'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0: rb = '0;
            1: rb = W'(M);
            2: rb = W'($urandom_range(1, 15));
            default: rb = W'($urandom);
         endcase
         run_op("rand", rop, ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
